// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the single-port RAM arbiter
package ram_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef logic req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t owner;
        logic     err;
        logic     is_write;
    } rsp_slot_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with last-granted pointer
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output req_idx_t           gnt_idx_o
);

    // rr_ptr holds the last granted index; hist_q marks that any grant has
    // happened since reset, so the first contention favours requester 0.
    req_idx_t rr_ptr;
    logic     hist_q;

    // Pick the winner for this cycle and build the one-hot grant.
    always_comb begin
        gnt_idx_o = 1'b0;
        case (req_i)
            2'b01:   gnt_idx_o = 1'b0;
            2'b10:   gnt_idx_o = 1'b1;
            2'b11:   gnt_idx_o = hist_q ? ~rr_ptr : 1'b0;
            default: gnt_idx_o = 1'b0;
        endcase
        gnt_o = 2'b00;
        if (|req_i) begin
            gnt_o = gnt_idx_o ? 2'b10 : 2'b01;
        end
    end

    // Remember the granted index on every grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= 1'b0;
            hist_q <= 1'b0;
        end else if (|req_i) begin
            rr_ptr <= gnt_idx_o;
            hist_q <= 1'b1;
        end
    end

endmodule

// File: rtl/ram_1p_arbiter.sv
// rtl/ram_1p_arbiter.sv - shares one single-port word RAM between two req/gnt/rvalid masters (option: RAM_ARB_OUT_REG_EN)
module ram_1p_arbiter
    import ram_arb_pkg::*;
#(
    parameter int          SIZE      = 1024,
    parameter int          AW        = $clog2(SIZE),
    parameter logic [31:0] BASE_ADDR = 32'h0010_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    input  logic [NUM_REQ-1:0][31:0] addr_i,
    input  logic [NUM_REQ-1:0]       we_i,
    input  logic [NUM_REQ-1:0][3:0]  be_i,
    input  logic [NUM_REQ-1:0][31:0] wdata_i,
    output logic [NUM_REQ-1:0]       rvalid_o,
    output logic [31:0]              rdata_o,
    output logic                     err_o,
    output logic                     ram_valid_o,
    output logic [AW-1:0]            ram_addr_o,
    output logic [3:0]               ram_we_o,
    output logic [31:0]              ram_wdata_o,
    input  logic [31:0]              ram_rdata_i
);

    localparam logic [32:0] WIN_BYTES = 33'(SIZE) * 33'd4;

    req_idx_t    sel;
    logic        any_gnt;
    logic [31:0] sel_addr;
    logic [31:0] offset;
    logic        in_range;
    logic        unused_offset_bits;

    rr_arbiter2 u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .gnt_idx_o (sel)
    );

    assign any_gnt  = |gnt_o;
    assign sel_addr = addr_i[sel];
    assign offset   = sel_addr - BASE_ADDR;
    assign in_range = (sel_addr >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);

    // Byte lane bits and the part of the offset above the window never reach the RAM.
    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

    // Out-of-range grants are accepted but never touch the RAM.
    assign ram_valid_o = any_gnt & in_range;
    assign ram_addr_o  = ram_valid_o ? offset[AW+1:2] : '0;
    assign ram_we_o    = (ram_valid_o & we_i[sel]) ? be_i[sel] : 4'b0000;
    assign ram_wdata_o = ram_valid_o ? wdata_i[sel] : 32'h0;

    rsp_slot_t slot_d;
    rsp_slot_t slot_q;

    // Describe the response owed for this cycle's grant.
    always_comb begin
        slot_d          = '0;
        slot_d.valid    = any_gnt;
        slot_d.owner    = sel;
        slot_d.err      = any_gnt & ~in_range;
        slot_d.is_write = we_i[sel];
    end

    // Response stage: lines up with the RAM's registered read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    logic [NUM_REQ-1:0] rsp_rvalid;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;

    // Steer the response to its owner; writes and errors return zero data.
    always_comb begin
        rsp_rvalid = '0;
        rsp_rdata  = 32'h0;
        rsp_err    = 1'b0;
        if (slot_q.valid) begin
            rsp_rvalid = slot_q.owner ? 2'b10 : 2'b01;
            rsp_err    = slot_q.err;
            if (!slot_q.err && !slot_q.is_write) begin
                rsp_rdata = ram_rdata_i;
            end
        end
    end

`ifdef RAM_ARB_OUT_REG_EN
    // Extra output stage to ease timing on the response path.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_o <= '0;
            rdata_o  <= 32'h0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= rsp_rvalid;
            rdata_o  <= rsp_rdata;
            err_o    <= rsp_err;
        end
    end
`else
    assign rvalid_o = rsp_rvalid;
    assign rdata_o  = rsp_rdata;
    assign err_o    = rsp_err;
`endif

endmodule

// File: tb/tb_ram_1p_arbiter.sv
// tb/tb_ram_1p_arbiter.sv - directed table-driven bench for ram_1p_arbiter
module tb_ram_1p_arbiter;

`ifdef RAM_ARB_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [31:0] BASE = 32'h0010_0000;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [1:0]       req_i;
    logic [1:0]       gnt_o;
    logic [1:0][31:0] addr_i;
    logic [1:0]       we_i;
    logic [1:0][3:0]  be_i;
    logic [1:0][31:0] wdata_i;
    logic [1:0]       rvalid_o;
    logic [31:0]      rdata_o;
    logic             err_o;
    logic             ram_valid_o;
    logic [9:0]       ram_addr_o;
    logic [3:0]       ram_we_o;
    logic [31:0]      ram_wdata_o;
    logic [31:0]      ram_rdata_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ram_1p_arbiter #(.SIZE(1024), .AW(10), .BASE_ADDR(BASE)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .ram_valid_o (ram_valid_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    // Behavioural single-port RAM with one-cycle registered read.
    logic [31:0] mem [0:1023];
    always @(posedge clk_i) begin
        if (ram_valid_o) begin
            ram_rdata_i <= mem[ram_addr_o];
            for (int b = 0; b < 4; b++) begin
                if (ram_we_o[b]) mem[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
            end
        end
    end

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0, a1;
        logic [1:0]  we;
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1;
        logic [1:0]  gnt;
        logic        rv;
        logic [9:0]  raddr;
        logic [3:0]  rwe;
        logic [31:0] rwd;
        logic        rsp_err;
        logic [31:0] rsp_rdata;
    } vec_t;

    function automatic vec_t mk(
        input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
        input logic [1:0] we, input logic [3:0] be0, input logic [3:0] be1,
        input logic [31:0] wd0, input logic [31:0] wd1, input logic [1:0] gnt,
        input logic rv, input logic [9:0] raddr, input logic [3:0] rwe,
        input logic [31:0] rwd, input logic rsp_err, input logic [31:0] rsp_rdata);
        vec_t v;
        v.req = req; v.a0 = a0; v.a1 = a1; v.we = we; v.be0 = be0; v.be1 = be1;
        v.wd0 = wd0; v.wd1 = wd1; v.gnt = gnt; v.rv = rv; v.raddr = raddr;
        v.rwe = rwe; v.rwd = rwd; v.rsp_err = rsp_err; v.rsp_rdata = rsp_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_i = 2'b00; we_i = 2'b00;
        addr_i[0] = 32'h0; addr_i[1] = 32'h0;
        be_i[0] = 4'h0; be_i[1] = 4'h0;
        wdata_i[0] = 32'h0; wdata_i[1] = 32'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " gnt"}, 32'(gnt_o), 32'h0);
        chk({tag, " rvalid"}, 32'(rvalid_o), 32'h0);
        chk({tag, " err"}, 32'(err_o), 32'h0);
        chk({tag, " rdata"}, rdata_o, 32'h0);
        chk({tag, " ram_valid"}, 32'(ram_valid_o), 32'h0);
        chk({tag, " ram_addr"}, 32'(ram_addr_o), 32'h0);
        chk({tag, " ram_we"}, 32'(ram_we_o), 32'h0);
        chk({tag, " ram_wdata"}, ram_wdata_o, 32'h0);
    endtask

    vec_t tbl [12];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[2]    = 32'h1234_5678;
        mem[4]    = 32'h0BAD_CAFE;
        mem[1023] = 32'hA5A5_0001;
        ram_rdata_i = 32'h0;

        //          req    a0            a1            we     be0    be1    wd0           wd1           gnt    rv  raddr  rwe    rwd           err  rsp_rdata
        tbl[0]  = mk(2'b00, 32'h0,        32'h0,        2'b00, 4'h0,  4'h0,  32'h0,        32'h0,        2'b00, 0,  10'd0, 4'h0,  32'h0,        0,   32'h0);
        tbl[1]  = mk(2'b01, 32'h0010_0008,32'h0,        2'b01, 4'h3,  4'h0,  32'hDEADBEEF, 32'h0,        2'b01, 1,  10'd2, 4'h3,  32'hDEADBEEF, 0,   32'h0);
        tbl[2]  = mk(2'b01, 32'h0010_0008,32'h0,        2'b00, 4'hF,  4'h0,  32'h0,        32'h0,        2'b01, 1,  10'd2, 4'h0,  32'h0,        0,   32'h1234BEEF);
        tbl[3]  = mk(2'b10, 32'h0,        32'h0,        2'b00, 4'h0,  4'hF,  32'h0,        32'h0,        2'b10, 0,  10'd0, 4'h0,  32'h0,        1,   32'h0);
        tbl[4]  = mk(2'b10, 32'h0,        32'h0010_1000,2'b00, 4'h0,  4'hF,  32'h0,        32'h0,        2'b10, 0,  10'd0, 4'h0,  32'h0,        1,   32'h0);
        tbl[5]  = mk(2'b10, 32'h0,        32'h0010_0FFF,2'b00, 4'h0,  4'hF,  32'h0,        32'h0,        2'b10, 1,  10'd1023, 4'h0, 32'h0,      0,   32'hA5A50001);
        tbl[6]  = mk(2'b11, 32'h0010_0010,32'h0010_0014,2'b10, 4'hF,  4'hF,  32'h0,        32'hCAFEF00D, 2'b01, 1,  10'd4, 4'h0,  32'h0,        0,   32'h0BADCAFE);
        tbl[7]  = mk(2'b11, 32'h0010_0010,32'h0010_0014,2'b10, 4'hF,  4'hF,  32'h0,        32'hCAFEF00D, 2'b10, 1,  10'd5, 4'hF,  32'hCAFEF00D, 0,   32'h0);
        tbl[8]  = tbl[6];
        tbl[9]  = tbl[7];
        tbl[10] = tbl[0];
        tbl[11] = tbl[0];

        // Reset hold, then idle after release.
        idle_inputs();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_all_zero("reset");
        @(posedge clk_i); #1 rst_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            chk_all_zero($sformatf("idle%0d", c));
        end

        // Table: one row per cycle, response compared LAT rows later.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            req_i = tbl[i].req; we_i = tbl[i].we;
            addr_i[0] = tbl[i].a0; addr_i[1] = tbl[i].a1;
            be_i[0] = tbl[i].be0; be_i[1] = tbl[i].be1;
            wdata_i[0] = tbl[i].wd0; wdata_i[1] = tbl[i].wd1;
            @(negedge clk_i);
            chk($sformatf("row%0d gnt", i), 32'(gnt_o), 32'(tbl[i].gnt));
            chk($sformatf("row%0d ram_valid", i), 32'(ram_valid_o), 32'(tbl[i].rv));
            chk($sformatf("row%0d ram_addr", i), 32'(ram_addr_o), 32'(tbl[i].raddr));
            chk($sformatf("row%0d ram_we", i), 32'(ram_we_o), 32'(tbl[i].rwe));
            chk($sformatf("row%0d ram_wdata", i), ram_wdata_o, tbl[i].rwd);
            if (i >= LAT) begin
                chk($sformatf("row%0d rvalid", i), 32'(rvalid_o), 32'(tbl[i-LAT].gnt));
                chk($sformatf("row%0d err", i), 32'(err_o), 32'(tbl[i-LAT].rsp_err));
                chk($sformatf("row%0d rdata", i), rdata_o, tbl[i-LAT].rsp_rdata);
            end else begin
                chk($sformatf("row%0d rvalid", i), 32'(rvalid_o), 32'h0);
            end
        end

        // Reset the cycle after a read grant: the response must vanish.
        @(posedge clk_i); #1;
        idle_inputs();
        req_i = 2'b01; addr_i[0] = BASE + 32'h10;
        @(negedge clk_i);
        chk("midrst gnt", 32'(gnt_o), 32'h1);
        @(posedge clk_i); #1;
        idle_inputs();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midrst rvalid in reset", 32'(rvalid_o), 32'h0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk($sformatf("midrst rvalid after%0d", c), 32'(rvalid_o), 32'h0);
            @(posedge clk_i); #1;
        end
        req_i = 2'b11; addr_i[0] = BASE; addr_i[1] = BASE + 32'h4;
        @(negedge clk_i);
        chk("post-reset first contention gnt", 32'(gnt_o), 32'h1);
        @(posedge clk_i); #1 idle_inputs();
        repeat (LAT) @(posedge clk_i);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
